mem_access_ctrl: RTL and testbench

Sequencing controller for the MIPS MEM stage. Accepts one load or store per request from the pipeline and drives a variable-latency data memory through a req/ack handshake. It generates byte-lane enables and aligned store data, and extracts, sign-extends or zero-extends load data. It holds the pipeline stalled until the access completes or times out.

---
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Bundle of pipeline request/response and data-memory bus signals for mem_access_ctrl.
// slave = controller view, master = requester/memory-side driver view.
interface mem_access_ctrl_if #(
   parameter int BITS_SIZE      = 32,
   parameter int BITS_EXTENSION = 2
);
   logic                      i_valid;
   logic                      i_write;
   logic [BITS_SIZE-1:0]      i_addr;
   logic [BITS_SIZE-1:0]      i_wdata;
   logic [BITS_EXTENSION-1:0] i_size;
   logic                      i_unsigned;
   logic                      o_stall;
   logic                      o_done;
   logic [BITS_SIZE-1:0]      o_rdata;
   logic                      o_mem_req;
   logic                      o_mem_we;
   logic [BITS_SIZE-1:0]      o_mem_addr;
   logic [BITS_SIZE-1:0]      o_mem_wdata;
   logic [3:0]                o_mem_be;
   logic                      i_mem_ack;
   logic [BITS_SIZE-1:0]      i_mem_rdata;
   logic                      o_misaligned;
   logic                      o_timeout;

   modport slave (
      input  i_valid, i_write, i_addr, i_wdata, i_size, i_unsigned, i_mem_ack, i_mem_rdata,
      output o_stall, o_done, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
             o_mem_be, o_misaligned, o_timeout
   );

   modport master (
      output i_valid, i_write, i_addr, i_wdata, i_size, i_unsigned, i_mem_ack, i_mem_rdata,
      input  o_stall, o_done, o_rdata, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
             o_mem_be, o_misaligned, o_timeout
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MIPS MEM-stage load/store sequencer over a variable-latency req/ack data memory.
// Optional `MEM_ACCESS_ALIGN_CHECK_EN: reject misaligned half/word accesses instead of forcing alignment.
module mem_access_ctrl #(
   parameter int BITS_SIZE      = 32,
   parameter int BITS_EXTENSION = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   mem_access_ctrl_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [BITS_EXTENSION-1:0] SZ_WORD = BITS_EXTENSION'(0);
   localparam logic [BITS_EXTENSION-1:0] SZ_BYTE = BITS_EXTENSION'(1);
   localparam logic [BITS_EXTENSION-1:0] SZ_HALF = BITS_EXTENSION'(2);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                    r_state;
   logic                      r_write;
   logic [1:0]                r_off;
   logic [BITS_EXTENSION-1:0] r_size;
   logic                      r_unsigned;
   logic [TW-1:0]             r_timer;
   logic                      r_mem_req;
   logic                      r_mem_we;
   logic [BITS_SIZE-1:0]      r_mem_addr;
   logic [BITS_SIZE-1:0]      r_mem_wdata;
   logic [3:0]                r_mem_be;
   logic                      r_done;
   logic [BITS_SIZE-1:0]      r_rdata;
   logic                      r_misaligned;
   logic                      r_timeout;

   logic [1:0]                w_off;
   logic                      w_reserved;
   logic                      w_misaligned;
   logic [3:0]                w_be;
   logic [BITS_SIZE-1:0]      w_wdata;

   function automatic logic [BITS_SIZE-1:0] f_extract(
      input logic [BITS_SIZE-1:0]      word,
      input logic [1:0]                off,
      input logic [BITS_EXTENSION-1:0] size,
      input logic                      uns
   );
      logic [BITS_SIZE-1:0] sh;
      sh = word >> {off, 3'b000};
      if (size == SZ_BYTE)
         f_extract = {{(BITS_SIZE-8){sh[7] & ~uns}}, sh[7:0]};
      else if (size == SZ_HALF)
         f_extract = {{(BITS_SIZE-16){sh[15] & ~uns}}, sh[15:0]};
      else
         f_extract = sh;
   endfunction

   // Request decode: lane enables, replicated store data and effective byte offset
   always_comb begin
      w_off        = bus.i_addr[1:0];
      w_reserved   = 1'b0;
      w_misaligned = 1'b0;
      w_be         = 4'b1111;
      w_wdata      = bus.i_wdata;
      case (bus.i_size)
         SZ_BYTE: begin
            w_be    = 4'b0001 << bus.i_addr[1:0];
            w_wdata = {4{bus.i_wdata[7:0]}};
         end
         SZ_HALF: begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            w_misaligned = bus.i_addr[0];
`endif
            w_off   = {bus.i_addr[1], 1'b0};
            w_be    = bus.i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{bus.i_wdata[15:0]}};
         end
         SZ_WORD: begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            w_misaligned = |bus.i_addr[1:0];
`endif
            w_off = 2'b00;
         end
         default: w_reserved = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= IDLE;
         r_write      <= 1'b0;
         r_off        <= 2'b00;
         r_size       <= '0;
         r_unsigned   <= 1'b0;
         r_timer      <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_be     <= 4'b0000;
         r_done       <= 1'b0;
         r_rdata      <= '0;
         r_misaligned <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.i_valid) begin
                  r_write      <= bus.i_write;
                  r_off        <= w_off;
                  r_size       <= bus.i_size;
                  r_unsigned   <= bus.i_unsigned;
                  r_mem_addr   <= {bus.i_addr[BITS_SIZE-1:2], 2'b00};
                  r_mem_be     <= w_be;
                  r_mem_wdata  <= w_wdata;
                  r_timer      <= '0;
                  r_timeout    <= 1'b0;
                  r_misaligned <= 1'b0;
                  r_rdata      <= '0;
                  if (w_reserved) begin
                     // Reserved size: no memory access, loads report all-ones
                     r_state <= RESP;
                     r_done  <= 1'b1;
                     r_rdata <= bus.i_write ? '0 : '1;
                  end else if (w_misaligned) begin
                     r_state      <= RESP;
                     r_done       <= 1'b1;
                     r_misaligned <= 1'b1;
                  end else begin
                     r_state   <= ACCESS;
                     r_mem_req <= 1'b1;
                     r_mem_we  <= bus.i_write;
                  end
               end
            end
            ACCESS: begin
               // Ack is checked first so it wins over a coincident timeout
               if (bus.i_mem_ack) begin
                  r_state   <= RESP;
                  r_done    <= 1'b1;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_rdata   <= r_write ? '0 : f_extract(bus.i_mem_rdata, r_off, r_size, r_unsigned);
               end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_state   <= RESP;
                  r_done    <= 1'b1;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_timeout <= 1'b1;
                  r_rdata   <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.o_stall      = ((r_state == IDLE) && bus.i_valid) || (r_state == ACCESS);
   assign bus.o_done       = r_done;
   assign bus.o_rdata      = r_rdata;
   assign bus.o_mem_req    = r_mem_req;
   assign bus.o_mem_we     = r_mem_we;
   assign bus.o_mem_addr   = r_mem_addr;
   assign bus.o_mem_wdata  = r_mem_wdata;
   assign bus.o_mem_be     = r_mem_be;
   assign bus.o_misaligned = r_misaligned;
   assign bus.o_timeout    = r_timeout;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected responses queued at request time, popped on o_done.
module tb_mem_access_ctrl;
   localparam int TO = 16;

   typedef struct {
      logic [31:0] rdata;
      logic        chk_rd;
      logic        mis;
      logic        tmo;
      int          done_cyc;
      int          reqs;
   } exp_t;

   logic i_clk;
   logic i_reset;
   int   n_checks;
   int   n_errors;
   exp_t sb_q[$];

   mem_access_ctrl_if #(.BITS_SIZE(32), .BITS_EXTENSION(2)) bus ();

   mem_access_ctrl #(.BITS_SIZE(32), .BITS_EXTENSION(2), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] rd, input logic chk, input logic mis,
                               input logic tmo, input int dc, input int rq);
      exp_t e;
      e.rdata = rd; e.chk_rd = chk; e.mis = mis; e.tmo = tmo; e.done_cyc = dc; e.reqs = rq;
      return e;
   endfunction

   // ack_n: request cycle (1-based) on which memory acks; 0 = never
   task automatic run_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input int ack_n, input logic [31:0] mem_word,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input exp_t e);
      exp_t got;
      int   reqcnt;
      bit   done_seen;
      sb_q.push_back(e);
      @(negedge i_clk);
      bus.i_valid = 1'b1; bus.i_write = wr; bus.i_addr = addr;
      bus.i_wdata = wdata; bus.i_size = size; bus.i_unsigned = uns;
      #1 check_eq({tag, "_stall_req"}, 32'(bus.o_stall), 32'd1);
      reqcnt = 0;
      done_seen = 1'b0;
      for (int k = 1; k <= 40 && !done_seen; k++) begin
         @(negedge i_clk);
         if (k == 1) bus.i_valid = 1'b0;
         if (bus.o_mem_req) begin
            reqcnt++;
            if (reqcnt == 1) begin
               check_eq({tag, "_addr"}, bus.o_mem_addr, exp_addr);
               check_eq({tag, "_be"}, 32'(bus.o_mem_be), 32'(exp_be));
               check_eq({tag, "_we"}, 32'(bus.o_mem_we), 32'(wr));
               check_eq({tag, "_wdata"}, bus.o_mem_wdata, exp_wd);
            end
            bus.i_mem_ack   = (reqcnt == ack_n);
            bus.i_mem_rdata = mem_word;
         end else begin
            bus.i_mem_ack = 1'b0;
         end
         if (bus.o_done) begin
            done_seen = 1'b1;
            got = sb_q.pop_front();
            check_eq({tag, "_done_cyc"}, 32'(k), 32'(got.done_cyc));
            check_eq({tag, "_req_cycles"}, 32'(reqcnt), 32'(got.reqs));
            if (got.chk_rd) check_eq({tag, "_rdata"}, bus.o_rdata, got.rdata);
            check_eq({tag, "_misaligned"}, 32'(bus.o_misaligned), 32'(got.mis));
            check_eq({tag, "_timeout"}, 32'(bus.o_timeout), 32'(got.tmo));
            check_eq({tag, "_stall_resp"}, 32'(bus.o_stall), 32'd0);
         end
      end
      if (!done_seen) begin
         check_eq({tag, "_done_seen"}, 32'd0, 32'd1);
         void'(sb_q.pop_front());
      end
      bus.i_mem_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      i_reset = 1'b0;
      bus.i_valid = 1'b0; bus.i_write = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
      bus.i_size = 2'b00; bus.i_unsigned = 1'b0; bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
      repeat (2) @(negedge i_clk);
      check_eq("rst_req", 32'(bus.o_mem_req), 32'd0);
      check_eq("rst_done", 32'(bus.o_done), 32'd0);
      check_eq("rst_rdata", bus.o_rdata, 32'd0);
      check_eq("rst_be", 32'(bus.o_mem_be), 32'd0);
      check_eq("rst_flags", {30'd0, bus.o_misaligned, bus.o_timeout}, 32'd0);
      check_eq("rst_stall", 32'(bus.o_stall), 32'd0);
      i_reset = 1'b1;

      run_req("ldb_s",  1'b0, 32'h103, 32'h0, 2'b01, 1'b0, 4, 32'h80FF_1234,
              32'h100, 4'b1000, 32'h0, mk(32'hFFFF_FF80, 1, 0, 0, 5, 4));
      run_req("ldh_u",  1'b0, 32'h102, 32'h0, 2'b10, 1'b1, 1, 32'h80FF_1234,
              32'h100, 4'b1100, 32'h0, mk(32'h0000_80FF, 1, 0, 0, 2, 1));
      run_req("ldh_s",  1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 2, 32'h80FF_1234,
              32'h100, 4'b1100, 32'h0, mk(32'hFFFF_80FF, 1, 0, 0, 3, 2));
      run_req("ldb_u1", 1'b0, 32'h101, 32'h0, 2'b01, 1'b1, 1, 32'h80FF_1234,
              32'h100, 4'b0010, 32'h0, mk(32'h0000_0012, 1, 0, 0, 2, 1));
      run_req("ldb_s0", 1'b0, 32'h100, 32'h0, 2'b01, 1'b0, 3, 32'h80FF_1234,
              32'h100, 4'b0001, 32'h0, mk(32'h0000_0034, 1, 0, 0, 4, 3));
      run_req("stb",    1'b1, 32'h201, 32'h1234_56AB, 2'b01, 1'b0, 1, 32'h0,
              32'h200, 4'b0010, 32'hABAB_ABAB, mk(32'h0, 0, 0, 0, 2, 1));
      run_req("sth",    1'b1, 32'h302, 32'h1234_5678, 2'b10, 1'b0, 2, 32'h0,
              32'h300, 4'b1100, 32'h5678_5678, mk(32'h0, 0, 0, 0, 3, 2));
      run_req("stw",    1'b1, 32'h404, 32'hCAFE_F00D, 2'b00, 1'b0, 1, 32'h0,
              32'h404, 4'b1111, 32'hCAFE_F00D, mk(32'h0, 0, 0, 0, 2, 1));
      run_req("ldw",    1'b0, 32'h200, 32'h0, 2'b00, 1'b0, 5, 32'hDEAD_BEEF,
              32'h200, 4'b1111, 32'h0, mk(32'hDEAD_BEEF, 1, 0, 0, 6, 5));
      run_req("tmo",    1'b0, 32'h400, 32'h0, 2'b00, 1'b0, 0, 32'h5555_5555,
              32'h400, 4'b1111, 32'h0, mk(32'h0, 1, 0, 1, TO + 1, TO));
      run_req("ack_last", 1'b0, 32'h400, 32'h0, 2'b00, 1'b0, TO, 32'h0BAD_F00D,
              32'h400, 4'b1111, 32'h0, mk(32'h0BAD_F00D, 1, 0, 0, TO + 1, TO));
      run_req("rsv_ld", 1'b0, 32'h500, 32'h0, 2'b11, 1'b0, 1, 32'h0,
              32'h500, 4'b1111, 32'h0, mk(32'hFFFF_FFFF, 1, 0, 0, 1, 0));
      run_req("rsv_st", 1'b1, 32'h500, 32'h77, 2'b11, 1'b0, 1, 32'h0,
              32'h500, 4'b1111, 32'h77, mk(32'h0, 0, 0, 0, 1, 0));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      run_req("misw",   1'b0, 32'h102, 32'h0, 2'b00, 1'b0, 1, 32'h1122_3344,
              32'h100, 4'b1111, 32'h0, mk(32'h0, 1, 1, 0, 1, 0));
      run_req("mish",   1'b0, 32'h103, 32'h0, 2'b10, 1'b1, 1, 32'h80FF_1234,
              32'h100, 4'b1100, 32'h0, mk(32'h0, 1, 1, 0, 1, 0));
`else
      run_req("misw",   1'b0, 32'h102, 32'h0, 2'b00, 1'b0, 1, 32'h1122_3344,
              32'h100, 4'b1111, 32'h0, mk(32'h1122_3344, 1, 0, 0, 2, 1));
      run_req("mish",   1'b0, 32'h103, 32'h0, 2'b10, 1'b1, 1, 32'h80FF_1234,
              32'h100, 4'b1100, 32'h0, mk(32'h0000_80FF, 1, 0, 0, 2, 1));
`endif

      // Reset two cycles into ACCESS, then a late ack that must be ignored
      @(negedge i_clk);
      bus.i_valid = 1'b1; bus.i_write = 1'b0; bus.i_addr = 32'h600; bus.i_size = 2'b00;
      @(negedge i_clk);
      bus.i_valid = 1'b0;
      check_eq("mid_req1", 32'(bus.o_mem_req), 32'd1);
      @(negedge i_clk);
      check_eq("mid_req2", 32'(bus.o_mem_req), 32'd1);
      i_reset = 1'b0;
      #1;
      check_eq("mid_rst_req", 32'(bus.o_mem_req), 32'd0);
      check_eq("mid_rst_stall", 32'(bus.o_stall), 32'd0);
      bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h9999_9999;
      @(negedge i_clk);
      i_reset = 1'b1;
      for (int j = 0; j < 2; j++) begin
         @(negedge i_clk);
         check_eq("late_ack_done", 32'(bus.o_done), 32'd0);
         check_eq("late_ack_req", 32'(bus.o_mem_req), 32'd0);
      end
      bus.i_mem_ack = 1'b0;
      run_req("post_rst", 1'b1, 32'h703, 32'h0000_00C3, 2'b01, 1'b0, 2, 32'h0,
              32'h700, 4'b1000, 32'hC3C3_C3C3, mk(32'h0, 0, 0, 0, 3, 2));
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
